nrisc_mc_core: RTL

Parametrised multicycle successor to the single-cycle 8-bit nRISC datapath. It keeps the same 8-bit instruction format: opcode[7:5], r1[4:3], r2[2:1], funct[0], imm3[2:0], target[4:0]. It also keeps the 4-entry register file and the COND flag. New in this block:
- configurable data and PC widths
- a control FSM
- req/ack handshaked instruction and data memory ports, so external memories may insert wait states
- PC-relative conditional branch
- sticky halt

---
 rtl/nrisc_mc_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/nrisc_mc_core.sv
// nrisc_mc_core: multicycle nRISC core (8-bit instruction format) with req/ack memory ports.
// Define NRISC_MC_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
module nrisc_mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [PC_W-1:0]   pc,
  output logic              cond,
  output logic              halted
`ifdef NRISC_MC_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_ld_data;
  logic [DATA_W-1:0] r_rf [0:3];
  logic              r_cond;
  logic              r_halted;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;

  logic [2:0]        w_op;
  logic [1:0]        w_r1;
  logic [1:0]        w_r2;
  logic              w_funct;
  logic [DATA_W-1:0] w_imm_sext;
  logic [PC_W-1:0]   w_tgt_sext;
  logic [PC_W-1:0]   w_tgt_zext;
  logic [PC_W-1:0]   w_pc_inc;

  assign w_op       = r_ir[7:5];
  assign w_r1       = r_ir[4:3];
  assign w_r2       = r_ir[2:1];
  assign w_funct    = r_ir[0];
  assign w_imm_sext = DATA_W'($signed(r_ir[2:0]));
  assign w_tgt_sext = PC_W'($signed(r_ir[4:0]));
  assign w_tgt_zext = PC_W'(r_ir[4:0]);
  assign w_pc_inc   = r_pc + PC_W'(1'b1);

  // Fetch request is a decode of the state register, held low while reset is asserted
  assign imem_req   = (r_state == S_FETCH) && RESET;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign cond       = r_cond;
  assign halted     = r_halted;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;

  // Control FSM, datapath registers, register file and memory-port outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_FETCH;
      r_pc         <= {PC_W{1'b0}};
      r_ir         <= 8'h00;
      r_a          <= {DATA_W{1'b0}};
      r_b          <= {DATA_W{1'b0}};
      r_ld_data    <= {DATA_W{1'b0}};
      r_rf[0]      <= {DATA_W{1'b0}};
      r_rf[1]      <= {DATA_W{1'b0}};
      r_rf[2]      <= {DATA_W{1'b0}};
      r_rf[3]      <= {DATA_W{1'b0}};
      r_cond       <= 1'b0;
      r_halted     <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= {DATA_W{1'b0}};
      r_dmem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_rf[w_r1];
          r_b     <= r_rf[w_r2];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_pc    <= w_pc_inc;
          case (w_op)
            3'b000: r_rf[w_r1] <= w_funct ? (r_a - r_b) : (r_a + r_b);
            3'b001: r_rf[w_r1] <= r_a + w_imm_sext;
            3'b010, 3'b011: begin
              r_pc         <= r_pc;
              r_state      <= S_MEM;
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_op[0];
              r_dmem_addr  <= r_b;
              r_dmem_wdata <= r_a;
            end
            3'b100: r_cond <= w_funct ? (r_a == r_b) : ($signed(r_a) < $signed(r_b));
            3'b101: begin
              if (r_cond) begin
                r_pc   <= r_pc + w_tgt_sext;
                r_cond <= 1'b0;
              end
            end
            3'b110: r_pc <= w_tgt_zext;
            3'b111: begin
              if (!w_funct) begin
                r_pc     <= r_pc;
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end
            end
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (r_dmem_we) begin
              r_pc    <= w_pc_inc;
              r_state <= S_FETCH;
            end else begin
              r_ld_data <= dmem_rdata;
              r_state   <= S_WB;
            end
          end
        end
        S_WB: begin
          r_rf[w_r1] <= r_ld_data;
          r_pc       <= w_pc_inc;
          r_state    <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

`ifdef NRISC_MC_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

  // Performance counters; both freeze once the core has halted
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (!r_halted) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if ((r_state == S_FETCH) && imem_ack) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
